// File: rtl/mem_manager_pkg.sv
// Shared types and helpers for the memory-manager read master.
// The word step (address/length increment) is derived from the byte-enable width.
package mem_manager_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } rm_state_t;

    localparam int DEFAULT_BYTEENABLEWIDTH = 4;

    function automatic int word_shift(input int bytes_per_word);
        return $clog2(bytes_per_word);
    endfunction

    localparam int DEFAULT_WORD_SHIFT = word_shift(DEFAULT_BYTEENABLEWIDTH);

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: the head word is presented on rdata whenever
// the FIFO is not empty. It reads as zero when empty.
module sync_fifo #(
    parameter int DATAWIDTH      = 32,
    parameter int FIFODEPTH      = 8,
    parameter int FIFODEPTH_LOG2 = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr,
    input  logic [DATAWIDTH-1:0]      wdata,
    input  logic                      rd,
    output logic [DATAWIDTH-1:0]      rdata,
    output logic                      empty,
    output logic                      full,
    output logic [FIFODEPTH_LOG2:0]   used
);

    logic [DATAWIDTH-1:0]      mem_q [FIFODEPTH];
    logic [FIFODEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [FIFODEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [FIFODEPTH_LOG2:0]   used_q, used_d;
    logic                      do_wr, do_rd;

    assign empty = (used_q == '0);
    assign full  = (used_q == (FIFODEPTH_LOG2+1)'(FIFODEPTH));
    assign used  = used_q;
    assign rdata = empty ? '0 : mem_q[rptr_q];

    // A pop on an empty FIFO is dropped; a push into a full FIFO is allowed only alongside a pop.
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        used_d = used_q;
        if (do_wr) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_rd) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({do_wr, do_rd})
            2'b10:   used_d = used_q + 1'b1;
            2'b01:   used_d = used_q - 1'b1;
            default: used_d = used_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            used_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            used_q <= used_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/avalon_read_master.sv
// Avalon-MM pipelined read master: issues single-word reads for a latched command
// and buffers returned words in a show-ahead FIFO for the user logic.
module avalon_read_master
    import mem_manager_pkg::*;
#(
    parameter int ADDRESSWIDTH    = 28,
    parameter int DATAWIDTH       = 32,
    parameter int BYTEENABLEWIDTH = 4,
    parameter int FIFODEPTH       = 8,
    parameter int FIFODEPTH_LOG2  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       control_fixed_location,
    input  logic [ADDRESSWIDTH-1:0]    control_read_base,
    input  logic [ADDRESSWIDTH-1:0]    control_read_length,
    input  logic                       control_go,
    output logic                       control_done,
    input  logic                       user_read_buffer,
    output logic [DATAWIDTH-1:0]       user_buffer_output_data,
    output logic                       user_data_available,
    output logic [ADDRESSWIDTH-1:0]    master_address,
    output logic                       master_read,
    output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
    input  logic [DATAWIDTH-1:0]       master_readdata,
    input  logic                       master_readdatavalid,
    input  logic                       master_waitrequest
);

    localparam int WORD_SHIFT = word_shift(BYTEENABLEWIDTH);
    localparam logic [ADDRESSWIDTH-1:0] WORD_STEP = ADDRESSWIDTH'(1) << WORD_SHIFT;
    localparam logic [ADDRESSWIDTH-1:0] WORD_MASK = ~(WORD_STEP - 1'b1);

    rm_state_t                 state_q, state_d;
    logic [ADDRESSWIDTH-1:0]   addr_q, addr_d;
    logic [ADDRESSWIDTH-1:0]   len_q, len_d;
    logic                      fixed_q, fixed_d;
    logic [FIFODEPTH_LOG2:0]   pend_q, pend_d;

    logic                      fifo_empty, fifo_full;
    logic [FIFODEPTH_LOG2:0]   fifo_used;
    logic [FIFODEPTH_LOG2+1:0] in_flight;
    logic                      has_credit;
    logic                      rd_req, accept, push;

    // Words already buffered plus words still owed by the slave must fit in the FIFO.
    assign in_flight  = {1'b0, fifo_used} + {1'b0, pend_q};
    assign has_credit = (in_flight < (FIFODEPTH_LOG2+2)'(FIFODEPTH)) && !fifo_full;

    assign accept = rd_req && !master_waitrequest;
    assign push   = master_readdatavalid && (pend_q != '0);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        fixed_d = fixed_q;
        pend_d  = pend_q;
        rd_req  = 1'b0;

        case ({accept, push})
            2'b10:   pend_d = pend_q + 1'b1;
            2'b01:   pend_d = pend_q - 1'b1;
            default: pend_d = pend_q;
        endcase

        case (state_q)
            IDLE: begin
                if (control_go) begin
                    addr_d  = control_read_base;
                    len_d   = control_read_length & WORD_MASK;
                    fixed_d = control_fixed_location;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rd_req = (len_q != '0) && has_credit;
                if (accept) begin
                    len_d = len_q - WORD_STEP;
                    if (!fixed_q) begin
                        addr_d = addr_q + WORD_STEP;
                    end
                end
                // Leave as soon as the final word lands so done follows it by one cycle.
                if ((len_d == '0) && (pend_d == '0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            fixed_q <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            fixed_q <= fixed_d;
            pend_q  <= pend_d;
        end
    end

    assign master_read       = rd_req;
    assign master_address    = addr_q;
    assign master_byteenable = '1;
    assign control_done      = (state_q == IDLE);
    assign user_data_available = !fifo_empty;

    sync_fifo #(
        .DATAWIDTH     (DATAWIDTH),
        .FIFODEPTH     (FIFODEPTH),
        .FIFODEPTH_LOG2(FIFODEPTH_LOG2)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .wr   (push),
        .wdata(master_readdata),
        .rd   (user_read_buffer),
        .rdata(user_buffer_output_data),
        .empty(fifo_empty),
        .full (fifo_full),
        .used (fifo_used)
    );

endmodule

// File: tb/tb_avalon_read_master.sv
// Scoreboard bench for avalon_read_master: expected addresses and user-side words
// are queued by the directed tests and consumed by a monitor as the DUT produces them.
module tb_avalon_read_master;

    localparam int AW  = 28;
    localparam int DW  = 32;
    localparam int BEW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          control_fixed_location;
    logic [AW-1:0] control_read_base;
    logic [AW-1:0] control_read_length;
    logic          control_go;
    logic          control_done;
    logic          user_read_buffer;
    logic [DW-1:0] user_buffer_output_data;
    logic          user_data_available;
    logic [AW-1:0] master_address;
    logic          master_read;
    logic [BEW-1:0] master_byteenable;
    logic [DW-1:0] master_readdata;
    logic          master_readdatavalid;
    logic          master_waitrequest;

    always #5 clk = ~clk;

    avalon_read_master dut (
        .clk                    (clk),
        .reset                  (reset),
        .control_fixed_location (control_fixed_location),
        .control_read_base      (control_read_base),
        .control_read_length    (control_read_length),
        .control_go             (control_go),
        .control_done           (control_done),
        .user_read_buffer       (user_read_buffer),
        .user_buffer_output_data(user_buffer_output_data),
        .user_data_available    (user_data_available),
        .master_address         (master_address),
        .master_read            (master_read),
        .master_byteenable      (master_byteenable),
        .master_readdata        (master_readdata),
        .master_readdatavalid   (master_readdatavalid),
        .master_waitrequest     (master_waitrequest)
    );

    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } resp_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            acc_cnt = 0;
    int            lat = 1;
    int            stall_n = 0;
    int            stall_cnt = 0;
    logic          stalled_prev = 1'b0;
    logic [AW-1:0] stall_addr = '0;
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_data_q[$];
    logic [DW-1:0] slave_data_q[$];
    resp_t         resp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", name);
    endtask

    // Avalon slave model: optional waitrequest stalls per request, fixed read latency.
    initial begin
        resp_t r;
        master_waitrequest   = 1'b0;
        master_readdatavalid = 1'b0;
        master_readdata      = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (master_read && stall_cnt < stall_n) begin
                master_waitrequest = 1'b1;
                stall_cnt++;
            end else begin
                master_waitrequest = 1'b0;
                stall_cnt = 0;
            end
            if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
                r = resp_q.pop_front();
                master_readdatavalid = 1'b1;
                master_readdata      = r.d;
            end else begin
                master_readdatavalid = 1'b0;
                master_readdata      = '0;
            end
        end
    end

    // Monitor: checks accepted read addresses and popped words against the scoreboard.
    initial begin
        logic [DW-1:0] dd;
        forever begin
            @(negedge clk);
            #3;
            if (!reset && stalled_prev && master_read)
                check("addr_held", 32'(master_address), 32'(stall_addr));
            if (!reset && master_read && !master_waitrequest) begin
                acc_cnt++;
                if (exp_addr_q.size() == 0)
                    fail_now("unexpected_read");
                else
                    check("read_addr", 32'(master_address), 32'(exp_addr_q.pop_front()));
                dd = (slave_data_q.size() > 0) ? slave_data_q.pop_front() : 32'hDEAD0000;
                resp_q.push_back('{due: cyc + lat, d: dd});
            end
            stalled_prev = !reset && master_read && master_waitrequest;
            if (stalled_prev) stall_addr = master_address;
            if (!reset && user_read_buffer && user_data_available) begin
                if (exp_data_q.size() == 0)
                    fail_now("unexpected_pop");
                else
                    check("pop_data", user_buffer_output_data, exp_data_q.pop_front());
            end
        end
    end

    task automatic start(input logic [AW-1:0] base, input logic [AW-1:0] len, input logic fx);
        @(negedge clk);
        control_read_base      = base;
        control_read_length    = len;
        control_fixed_location = fx;
        control_go             = 1'b1;
        @(negedge clk);
        control_go             = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_acc(input int n, input int budget);
        int t = 0;
        while (acc_cnt < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (acc_cnt < n) fail_now("wait_acc_timeout");
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (!control_done && t < budget) begin
            @(negedge clk);
            #2;
            t++;
        end
        if (!control_done) fail_now("wait_done_timeout");
    endtask

    task automatic pop_words(input int n);
        int got = 0;
        int t = 0;
        while (got < n && t < 200) begin
            @(negedge clk);
            #1;
            if (user_data_available) begin
                user_read_buffer = 1'b1;
                got++;
            end else begin
                user_read_buffer = 1'b0;
            end
            t++;
        end
        @(negedge clk);
        user_read_buffer = 1'b0;
        if (got < n) fail_now("pop_timeout");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc0;
        bit  found;
        reset                  = 1'b1;
        control_fixed_location = 1'b0;
        control_read_base      = '0;
        control_read_length    = '0;
        control_go             = 1'b0;
        user_read_buffer       = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #2;
        check("rst_read", 32'(master_read), 32'd0);
        check("rst_addr", 32'(master_address), 32'd0);
        check("rst_done", 32'(control_done), 32'd1);
        check("rst_avail", 32'(user_data_available), 32'd0);
        check("rst_data", user_buffer_output_data, 32'd0);
        check("byteenable", 32'(master_byteenable), 32'hF);

        // Single fixed-address word, two-cycle slave latency.
        lat = 2;
        acc0 = acc_cnt;
        exp_addr_q.push_back(28'h8000000);
        slave_data_q.push_back(32'hAAAA0000);
        exp_data_q.push_back(32'hAAAA0000);
        start(28'h8000000, 28'd4, 1'b1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #2;
            if (master_readdatavalid) found = 1;
        end
        if (!found) fail_now("t1_no_valid");
        check("t1_done_at_valid", 32'(control_done), 32'd0);
        @(negedge clk);
        #2;
        check("t1_done_after_valid", 32'(control_done), 32'd1);
        check("t1_avail", 32'(user_data_available), 32'd1);
        check("t1_head", user_buffer_output_data, 32'hAAAA0000);
        check("t1_reads", 32'(acc_cnt - acc0), 32'd1);
        pop_words(1);
        #2;
        check("t1_empty", 32'(user_data_available), 32'd0);

        // Incrementing burst with two stall cycles per request.
        lat = 1;
        stall_n = 2;
        acc0 = acc_cnt;
        for (int i = 0; i < 4; i++) begin
            exp_addr_q.push_back(28'h8000008 + 28'(4 * i));
            slave_data_q.push_back(32'h22220000 + 32'(i));
            exp_data_q.push_back(32'h22220000 + 32'(i));
        end
        start(28'h8000008, 28'd16, 1'b0);
        wait_done(200);
        check("t2_reads", 32'(acc_cnt - acc0), 32'd4);
        pop_words(4);
        #2;
        check("t2_empty", 32'(user_data_available), 32'd0);
        stall_n = 0;

        // Backpressure: ten words into an eight-entry FIFO with no pops.
        acc0 = acc_cnt;
        for (int i = 0; i < 10; i++) begin
            exp_addr_q.push_back(28'h0000100 + 28'(4 * i));
            slave_data_q.push_back(32'h33330000 + 32'(i));
            exp_data_q.push_back(32'h33330000 + 32'(i));
        end
        start(28'h0000100, 28'd40, 1'b0);
        wait_cycles(30);
        #2;
        check("t3_reads_full", 32'(acc_cnt - acc0), 32'd8);
        check("t3_read_stopped", 32'(master_read), 32'd0);
        check("t3_not_done", 32'(control_done), 32'd0);
        pop_words(3);
        wait_cycles(20);
        #2;
        check("t3_reads_all", 32'(acc_cnt - acc0), 32'd10);
        check("t3_done", 32'(control_done), 32'd1);
        pop_words(7);
        #2;
        check("t3_empty", 32'(user_data_available), 32'd0);

        // Zero and sub-word lengths: one ISSUE cycle, no reads.
        acc0 = acc_cnt;
        start(28'h0000400, 28'd0, 1'b0);
        #2;
        check("t4_len0_busy", 32'(control_done), 32'd0);
        check("t4_len0_noread", 32'(master_read), 32'd0);
        @(negedge clk);
        #2;
        check("t4_len0_done", 32'(control_done), 32'd1);
        start(28'h0000400, 28'd3, 1'b0);
        #2;
        check("t4_len3_busy", 32'(control_done), 32'd0);
        check("t4_len3_noread", 32'(master_read), 32'd0);
        @(negedge clk);
        #2;
        check("t4_len3_done", 32'(control_done), 32'd1);
        check("t4_reads", 32'(acc_cnt - acc0), 32'd0);
        check("t4_avail", 32'(user_data_available), 32'd0);

        // Reset after two of six reads; the late returns must be discarded.
        lat = 4;
        acc0 = acc_cnt;
        for (int i = 0; i < 6; i++) begin
            exp_addr_q.push_back(28'h0000200 + 28'(4 * i));
            slave_data_q.push_back(32'h55550000 + 32'(i));
        end
        start(28'h0000200, 28'd24, 1'b0);
        wait_acc(acc0 + 2, 50);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_addr_q.delete();
        slave_data_q.delete();
        wait_cycles(10);
        #2;
        check("t5_reads", 32'(acc_cnt - acc0), 32'd2);
        check("t5_read", 32'(master_read), 32'd0);
        check("t5_done", 32'(control_done), 32'd1);
        check("t5_avail", 32'(user_data_available), 32'd0);
        check("t5_data", user_buffer_output_data, 32'd0);

        // Push and pop in the same cycle with one word buffered.
        lat = 3;
        for (int i = 0; i < 2; i++) begin
            exp_addr_q.push_back(28'h0000300 + 28'(4 * i));
            slave_data_q.push_back(32'h66660001 + 32'(i));
            exp_data_q.push_back(32'h66660001 + 32'(i));
        end
        start(28'h0000300, 28'd8, 1'b0);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            #2;
            if (master_readdatavalid && user_data_available) begin
                user_read_buffer = 1'b1;
                found = 1;
            end
        end
        if (!found) fail_now("t6_no_overlap");
        @(negedge clk);
        user_read_buffer = 1'b0;
        #2;
        check("t6_avail", 32'(user_data_available), 32'd1);
        check("t6_head", user_buffer_output_data, 32'h66660002);
        wait_done(50);
        pop_words(1);
        #2;
        check("t6_empty", 32'(user_data_available), 32'd0);

        check("left_exp_addr", 32'(exp_addr_q.size()), 32'd0);
        check("left_exp_data", 32'(exp_data_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
